// File: rtl/eq_fir_mac.sv
// eq_fir_mac: sequential one-tap-per-clock MAC FIR stage with double-buffered coefficients.
// Define FIR_SAT_EN to saturate sampleOut to 16 bits; otherwise the output wraps.
module eq_fir_mac #(
    parameter int NTAPS = 4,
    parameter int SHIFT = 15,
    parameter int ACCW  = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tapValid,
    input  logic [7:0]  tapnum,
    input  logic [15:0] desiredTap,
    input  logic        sampleValid,
    input  logic [15:0] sampleIn,
    output logic        sampleReady,
    output logic        outValid,
    output logic [15:0] sampleOut,
    output logic        tapsLoaded
);
    localparam int            KW    = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NTAPS - 1);
    localparam logic [8:0]    NT9   = 9'(NTAPS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]             state;
    logic signed [15:0]     sh [NTAPS];
    logic signed [15:0]     ac [NTAPS];
    logic signed [15:0]     x  [NTAPS];
    logic [NTAPS-1:0]       wm;
    logic signed [ACCW-1:0] acc;
    logic [KW-1:0]          k;
    logic                   tap_wr;
    logic                   accept;
    logic signed [31:0]     prod;
    logic [15:0]            fmt;

    assign tap_wr      = tapValid && ({1'b0, tapnum} < NT9);
    assign tapsLoaded  = &wm;
    assign sampleReady = (state == IDLE) && tapsLoaded;
    assign accept      = sampleValid && sampleReady;
    assign prod        = 32'(ac[k]) * 32'(x[k]);

`ifdef FIR_SAT_EN
    logic signed [ACCW-1:0] shifted;
    assign shifted = acc >>> SHIFT;

    // In range exactly when every bit above bit 15 matches the sign.
    always_comb begin
        if (shifted[ACCW-1:15] == '0 || shifted[ACCW-1:15] == '1)
            fmt = shifted[15:0];
        else if (shifted[ACCW-1])
            fmt = 16'h8000;
        else
            fmt = 16'h7FFF;
    end
`else
    assign fmt = 16'(acc >>> SHIFT);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wm        <= '0;
            acc       <= '0;
            k         <= '0;
            outValid  <= 1'b0;
            sampleOut <= '0;
            for (int unsigned i = 0; i < NTAPS; i++) begin
                sh[i] <= '0;
                ac[i] <= '0;
                x[i]  <= '0;
            end
        end else begin
            outValid <= 1'b0;
            if (tap_wr) begin
                sh[tapnum[KW-1:0]] <= desiredTap;
                wm[tapnum[KW-1:0]] <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // ac samples sh before any same-edge write lands, so a sample never sees a mixed set.
                    if (accept) begin
                        x[0] <= sampleIn;
                        for (int unsigned i = 1; i < NTAPS; i++)
                            x[i] <= x[i-1];
                        ac    <= sh;
                        acc   <= '0;
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACCW'(prod);
                    k   <= k + 1'b1;
                    if (k == KLAST)
                        state <= OUT;
                end
                OUT: begin
                    sampleOut <= fmt;
                    outValid  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
